// File: rtl/tictactoe_if.sv
`default_nettype none
// ============================================================================
// Module      : tictactoe_if
// Description : Move request / game status bundle between the input-decode
//               logic (master) and the tic-tac-toe controller (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface tictactoe_if;
    logic        new_game;
    logic        move_valid;
    logic [3:0]  move_pos;
    logic [17:0] board;
    logic [2:0]  status;
    logic        move_ack;
    logic        move_err;
    logic [3:0]  move_count;

    modport master (
        output new_game, move_valid, move_pos,
        input  board, status, move_ack, move_err, move_count
    );

    modport slave (
        input  new_game, move_valid, move_pos,
        output board, status, move_ack, move_err, move_count
    );
endinterface
`default_nettype wire

// File: rtl/tictactoe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tictactoe_ctrl
// Description : Two-player tic-tac-toe match sequencer. Checks move requests,
//               writes accepted moves into the 3x3 board, alternates turns and
//               reports win/draw. State lives in two-phase master/slave
//               storage (ph2 master, ph1 slave); one cycle request latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tictactoe_ctrl #(
    parameter bit FIRST_O = 1'b0
) (
    input  wire logic    ph1,
    input  wire logic    ph2,
    input  wire logic    reset,
    tictactoe_if.slave   bus
);

    typedef enum logic [2:0] {
        ST_X_TURN = 3'd0,
        ST_O_TURN = 3'd1,
        ST_X_WIN  = 3'd2,
        ST_O_WIN  = 3'd3,
        ST_DRAW   = 3'd4
    } state_t;

    localparam state_t c_start = FIRST_O ? ST_O_TURN : ST_X_TURN;

    // One 9-bit cell mask per winning line (bit i = cell i): rows, columns,
    // then the two diagonals.
    localparam logic [71:0] c_lines = {
        9'b001_010_100,  // cells 2,4,6
        9'b100_010_001,  // cells 0,4,8
        9'b100_100_100,  // cells 2,5,8
        9'b010_010_010,  // cells 1,4,7
        9'b001_001_001,  // cells 0,3,6
        9'b111_000_000,  // cells 6,7,8
        9'b000_111_000,  // cells 3,4,5
        9'b000_000_111   // cells 0,1,2
    };

    // Slave (visible) state
    logic [17:0] r_board;
    state_t      r_state;
    logic [3:0]  r_count;
    logic        r_ack;
    logic        r_err;

    // Master state
    logic [17:0] r_board_m;
    state_t      r_state_m;
    logic [3:0]  r_count_m;
    logic        r_ack_m;
    logic        r_err_m;

    // Next-state values
    logic [17:0] w_board_d;
    state_t      w_state_d;
    logic [3:0]  w_count_d;
    logic        w_ack_d;
    logic        w_err_d;

    logic [8:0]  w_hit;
    logic [8:0]  w_empty;
    logic [8:0]  w_own;
    logic [7:0]  w_line_hit;
    logic [17:0] w_board_mv;
    logic [1:0]  w_mark;
    logic [3:0]  w_count_inc;
    logic        w_clear;
    logic        w_in_play;
    logic        w_pos_ok;
    logic        w_accept;
    logic        w_win;

    assign w_clear     = reset | bus.new_game;
    assign w_in_play   = (r_state == ST_X_TURN) || (r_state == ST_O_TURN);
    assign w_pos_ok    = (bus.move_pos <= 4'd8);
    assign w_mark      = (r_state == ST_O_TURN) ? 2'b10 : 2'b01;
    assign w_count_inc = r_count + 4'd1;

    // Per-cell decode: target hit, emptiness, candidate board and the set of
    // cells the mover would own after placing the mark.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_cell
            assign w_hit[gi]             = (bus.move_pos == 4'(gi));
            assign w_empty[gi]           = (r_board[2*gi +: 2] == 2'b00);
            assign w_board_mv[2*gi +: 2] = w_hit[gi] ? w_mark : r_board[2*gi +: 2];
            assign w_own[gi]             = (w_board_mv[2*gi +: 2] == w_mark);
        end
    endgenerate

    // Only the player who just moved can complete a line.
    genvar li;
    generate
        for (li = 0; li < 8; li++) begin : g_line
            assign w_line_hit[li] = ((w_own & c_lines[9*li +: 9]) == c_lines[9*li +: 9]);
        end
    endgenerate

    assign w_win    = |w_line_hit;
    assign w_accept = bus.move_valid & w_in_play & w_pos_ok & (|(w_hit & w_empty));

    // Next-state selection: restart overrides any move; otherwise accept,
    // reject or idle the current request.
    always_comb begin
        w_board_d = r_board;
        w_state_d = r_state;
        w_count_d = r_count;
        w_ack_d   = 1'b0;
        w_err_d   = 1'b0;
        if (w_clear) begin
            w_board_d = '0;
            w_state_d = c_start;
            w_count_d = 4'd0;
        end else if (w_accept) begin
            w_board_d = w_board_mv;
            w_count_d = w_count_inc;
            w_ack_d   = 1'b1;
            if (w_win) begin
                w_state_d = (r_state == ST_X_TURN) ? ST_X_WIN : ST_O_WIN;
            end else if (w_count_inc == 4'd9) begin
                w_state_d = ST_DRAW;
            end else begin
                w_state_d = (r_state == ST_X_TURN) ? ST_O_TURN : ST_X_TURN;
            end
        end else if (bus.move_valid) begin
            w_err_d = 1'b1;
        end
    end

    // Master stage: transparent during ph2, holds the computed next state.
    always_latch begin
        if (ph2) begin
            r_board_m <= w_board_d;
            r_state_m <= w_state_d;
            r_count_m <= w_count_d;
            r_ack_m   <= w_ack_d;
            r_err_m   <= w_err_d;
        end
    end

    // Slave stage: transparent during ph1, publishes the master contents.
    always_latch begin
        if (ph1) begin
            r_board <= r_board_m;
            r_state <= r_state_m;
            r_count <= r_count_m;
            r_ack   <= r_ack_m;
            r_err   <= r_err_m;
        end
    end

    assign bus.board      = r_board;
    assign bus.status     = r_state;
    assign bus.move_count = r_count;
    assign bus.move_ack   = r_ack;
    assign bus.move_err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_tictactoe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tictactoe_ctrl
// Description : Scoreboard bench for tictactoe_ctrl. Drives the same request
//               stream into an X-first and an O-first instance; a game model
//               predicts each response, monitors pop and compare.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tictactoe_ctrl;

    logic ph1;
    logic ph2;
    logic reset;

    tictactoe_if bus0 ();
    tictactoe_if bus1 ();

    tictactoe_ctrl #(.FIRST_O(1'b0)) u_dut_x (
        .ph1   (ph1),
        .ph2   (ph2),
        .reset (reset),
        .bus   (bus0)
    );

    tictactoe_ctrl #(.FIRST_O(1'b1)) u_dut_o (
        .ph1   (ph1),
        .ph2   (ph2),
        .reset (reset),
        .bus   (bus1)
    );

    // Non-overlapping two-phase clock, 20 time-unit period
    initial begin
        ph1 = 1'b0;
        ph2 = 1'b0;
        forever begin
            #1 ph1 = 1'b1;
            #4 ph1 = 1'b0;
            #5 ph2 = 1'b1;
            #4 ph2 = 1'b0;
            #6;
        end
    end

    // Expected response: {board[17:0], status[2:0], ack, err, count[3:0]}
    logic [27:0] q0[$];
    logic [27:0] q1[$];
    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain game rules on a cell array
    int cells [2][9];
    int mstat [2];
    int mcnt  [2];
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic bit has_line(input int k, input int who);
        for (int l = 0; l < 8; l++)
            if (cells[k][lines[l][0]] == who && cells[k][lines[l][1]] == who &&
                cells[k][lines[l][2]] == who)
                return 1'b1;
        return 1'b0;
    endfunction

    task automatic predict(input int k, input bit clr, input bit v, input int pos,
                           output logic [27:0] e);
        bit ack = 0;
        bit err = 0;
        logic [17:0] b;
        if (clr) begin
            for (int i = 0; i < 9; i++) cells[k][i] = 0;
            mcnt[k]  = 0;
            mstat[k] = (k == 1) ? 1 : 0;
        end else if (v) begin
            if (mstat[k] <= 1 && pos <= 8 && cells[k][pos] == 0) begin
                int who = (mstat[k] == 0) ? 1 : 2;
                cells[k][pos] = who;
                mcnt[k]++;
                ack = 1;
                if (has_line(k, who))  mstat[k] = (who == 1) ? 2 : 3;
                else if (mcnt[k] == 9) mstat[k] = 4;
                else                   mstat[k] = 1 - mstat[k];
            end else begin
                err = 1;
            end
        end
        for (int i = 0; i < 9; i++) b[2*i +: 2] = 2'(cells[k][i]);
        e = {b, 3'(mstat[k]), ack, err, 4'(mcnt[k])};
    endtask

    // Issue one cycle's request to both instances and queue the predictions
    task automatic req(input bit r, input bit ng, input bit v, input int pos);
        logic [27:0] e;
        @(negedge ph1);
        reset           = r;
        bus0.new_game   = ng;
        bus1.new_game   = ng;
        bus0.move_valid = v;
        bus1.move_valid = v;
        bus0.move_pos   = 4'(pos);
        bus1.move_pos   = 4'(pos);
        predict(0, r | ng, v, pos, e);
        q0.push_back(e);
        predict(1, r | ng, v, pos, e);
        q1.push_back(e);
    endtask

    task automatic mv(input int pos);
        req(1'b0, 1'b0, 1'b1, pos);
    endtask

    // Monitor for the X-first instance: outputs settle after ph1 rises
    initial begin
        logic [27:0] e, a;
        forever begin
            @(posedge ph1);
            #2;
            if (q0.size() > 0) begin
                e = q0.pop_front();
                a = {bus0.board, bus0.status, bus0.move_ack, bus0.move_err, bus0.move_count};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL dut_x t=%0t board=%b/%b status=%0d/%0d ack=%b/%b err=%b/%b count=%0d/%0d (actual/required)",
                             $time, a[27:10], e[27:10], a[9:7], e[9:7], a[6], e[6], a[5], e[5], a[3:0], e[3:0]);
                end
            end
        end
    end

    // Monitor for the O-first instance
    initial begin
        logic [27:0] e, a;
        forever begin
            @(posedge ph1);
            #2;
            if (q1.size() > 0) begin
                e = q1.pop_front();
                a = {bus1.board, bus1.status, bus1.move_ack, bus1.move_err, bus1.move_count};
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL dut_o t=%0t board=%b/%b status=%0d/%0d ack=%b/%b err=%b/%b count=%0d/%0d (actual/required)",
                             $time, a[27:10], e[27:10], a[9:7], e[9:7], a[6], e[6], a[5], e[5], a[3:0], e[3:0]);
                end
            end
        end
    end

    initial begin
        int draw_seq [9] = '{4, 0, 2, 6, 3, 5, 1, 7, 8};
        int row_seq  [5] = '{0, 3, 1, 4, 2};
        int diag_seq [5] = '{2, 0, 4, 1, 6};
        reset         = 1'b1;
        bus0.new_game = 1'b0;  bus1.new_game = 1'b0;
        bus0.move_valid = 1'b0; bus1.move_valid = 1'b0;
        bus0.move_pos = 4'd0;  bus1.move_pos = 4'd0;

        // Reset, including a move dropped under reset
        req(1, 0, 0, 0);
        req(1, 0, 1, 4);

        // Full game ending in a draw for the X-first instance
        foreach (draw_seq[i]) mv(draw_seq[i]);
        mv(0);

        // Row win, then a move after the game is over
        req(1, 0, 0, 0);
        foreach (row_seq[i]) mv(row_seq[i]);
        mv(8);

        // Illegal position and occupied cell
        req(1, 0, 0, 0);
        mv(12);
        mv(4);
        mv(4);

        // Back-to-back moves then an idle cycle
        req(0, 1, 0, 0);
        mv(0); mv(1); mv(2);
        req(0, 0, 0, 0);

        // new_game with a simultaneous move at three moves in
        req(0, 1, 1, 5);
        req(0, 0, 0, 0);

        // Diagonal 2,4,6 (O wins on the O-first instance)
        req(0, 1, 0, 0);
        foreach (diag_seq[i]) mv(diag_seq[i]);
        mv(3);

        // Randomized play with occasional restarts and illegal positions
        for (int n = 0; n < 800; n++) begin
            int pos;
            bit r, ng, v;
            r   = ($urandom_range(0, 59) == 0);
            ng  = ($urandom_range(0, 29) == 0);
            v   = ($urandom_range(0, 3) != 0);
            pos = ($urandom_range(0, 9) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
            req(r, ng, v, pos);
        end
        req(0, 0, 0, 0);

        // Drain both scoreboards within a bounded number of cycles
        for (int i = 0; i < 10 && (q0.size() > 0 || q1.size() > 0); i++) @(posedge ph2);
        if (q0.size() > 0 || q1.size() > 0) begin
            n_bad++;
            $display("FAIL drain pending=%0d/%0d required=0/0", q0.size(), q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
